pic_msg_builder: RTL and testbench

- Upstream message source for the PIC MCU serial link.
- Runs the power-up sequence (wait, firmware-version message, wait, logo command).
- Then arbitrates runtime events (PTT change, bootloader request, IP address update) into framed byte messages.
- Delivers bytes over a valid/ready stream to the bit-level serialiser that drives the open-drain MCU pins.

---
 rtl/pic_cmd_pkg.sv | 36 +++
 rtl/pic_delay_timer.sv | 37 +++
 rtl/pic_msg_builder.sv | 171 +++++++++++++++++
 tb/tb_pic_msg_builder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_cmd_pkg.sv
// Command codes, message lengths, sequencer states and frame builders for the PIC MCU link.
// Frames are built left-aligned in a 72-bit buffer: byte 0 sits in [71:64].
package pic_cmd_pkg;

    localparam int CNT_W = 24;

    localparam logic [7:0] CMD_FW       = 8'h01;
    localparam logic [7:0] CMD_LOGO     = 8'h02;
    localparam logic [7:0] CMD_IP       = 8'h03;
    localparam logic [7:0] CMD_BOOT     = 8'h04;
    localparam logic [7:0] CMD_PTT_ON   = 8'h05;
    localparam logic [7:0] CMD_PTT_OFF  = 8'h06;

    localparam logic [3:0] MSG_LEN_LONG  = 4'd9;
    localparam logic [3:0] MSG_LEN_SHORT = 4'd1;

    typedef enum logic [2:0] {
        ST_WAIT0,
        ST_VER,
        ST_WAIT1,
        ST_LOGO,
        ST_IDLE,
        ST_SEND
    } state_t;

    function automatic logic [71:0] short_msg(input logic [7:0] code);
        return {code, 64'h0};
    endfunction

    // Each IP octet is preceded by its 1-based position tag.
    function automatic logic [71:0] ip_msg(input logic [31:0] ip);
        return {CMD_IP, 8'h01, ip[31:24], 8'h02, ip[23:16],
                8'h03, ip[15:8], 8'h04, ip[7:0]};
    endfunction

endpackage

// File: rtl/pic_delay_timer.sv
// Shared 24-bit down-counter; done is high while the count is zero, so a load of 0 gives one pass-through cycle.
// Load takes effect on the next edge; no backpressure.
module pic_delay_timer
    import pic_cmd_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/pic_msg_builder.sv
// Power-up sequencer and event arbiter producing framed bytes for the PIC serialiser; first byte one cycle after selection.
// Bytes are held while tx_ready is low; one idle cycle follows every tx_last transfer.
module pic_msg_builder
    import pic_cmd_pkg::*;
#(
    parameter logic [63:0] FW_VERSION    = 64'h6E6F207665720000,
    parameter int          STARTUP_DELAY = 4000,
    parameter int          LOGO_DELAY    = 240000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ptt,
    input  logic [31:0] ip_addr,
    input  logic        ip_valid,
    input  logic        boot_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy
);

    localparam logic [CNT_W-1:0] STARTUP_CNT = CNT_W'(STARTUP_DELAY);
    localparam logic [CNT_W-1:0] LOGO_CNT    = CNT_W'(LOGO_DELAY);

    state_t        state_q, state_d;
    logic [71:0]   msg_q, msg_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    idx_q, idx_d;
    logic          vld_q, vld_d;
    logic          ptt_sent_q, ptt_sent_d;
    logic          boot_pend_q, boot_pend_d;
    logic          ip_pend_q, ip_pend_d;
    logic [31:0]   ip_shadow_q, ip_shadow_d;

    logic          tmr_load;
    logic          tmr_done;
    logic          xfer;
    logic          last_byte;
    logic          sel_boot;
    logic          sel_ip;

    pic_delay_timer #(
        .RESET_VAL (STARTUP_CNT)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (LOGO_CNT),
        .done     (tmr_done)
    );

    assign xfer      = vld_q && tx_ready;
    assign last_byte = (idx_q == len_q - 4'd1);

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        len_d       = len_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        ptt_sent_d  = ptt_sent_q;
        boot_pend_d = boot_pend_q;
        ip_pend_d   = ip_pend_q;
        ip_shadow_d = ip_shadow_q;
        tmr_load    = 1'b0;
        sel_boot    = 1'b0;
        sel_ip      = 1'b0;

        case (state_q)
            ST_WAIT0: begin
                if (tmr_done) begin
                    msg_d   = {CMD_FW, FW_VERSION};
                    len_d   = MSG_LEN_LONG;
                    idx_d   = 4'd0;
                    vld_d   = 1'b1;
                    state_d = ST_VER;
                end
            end
            ST_WAIT1: begin
                if (tmr_done) begin
                    msg_d   = short_msg(CMD_LOGO);
                    len_d   = MSG_LEN_SHORT;
                    idx_d   = 4'd0;
                    vld_d   = 1'b1;
                    state_d = ST_LOGO;
                end
            end
            ST_VER, ST_LOGO, ST_SEND: begin
                if (xfer) begin
                    if (last_byte) begin
                        vld_d = 1'b0;
                        if (state_q == ST_VER) begin
                            tmr_load = 1'b1;
                            state_d  = ST_WAIT1;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        msg_d = msg_q << 8;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                // Fixed priority PTT > boot > IP; PTT compares the live level with what was last reported.
                if (ptt != ptt_sent_q) begin
                    msg_d      = short_msg(ptt ? CMD_PTT_ON : CMD_PTT_OFF);
                    len_d      = MSG_LEN_SHORT;
                    ptt_sent_d = ptt;
                end else if (boot_pend_q) begin
                    msg_d      = short_msg(CMD_BOOT);
                    len_d      = MSG_LEN_SHORT;
                    sel_boot   = 1'b1;
                end else if (ip_pend_q) begin
                    msg_d      = ip_msg(ip_shadow_q);
                    len_d      = MSG_LEN_LONG;
                    sel_ip     = 1'b1;
                end
                if ((ptt != ptt_sent_q) || boot_pend_q || ip_pend_q) begin
                    idx_d   = 4'd0;
                    vld_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = ST_WAIT0;
            end
        endcase

        // A strobe coinciding with selection wins, so the newer request stays pending.
        if (sel_boot) boot_pend_d = 1'b0;
        if (boot_req) boot_pend_d = 1'b1;
        if (sel_ip)   ip_pend_d   = 1'b0;
        if (ip_valid) begin
            ip_pend_d   = 1'b1;
            ip_shadow_d = ip_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT0;
            msg_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
            ptt_sent_q  <= 1'b0;
            boot_pend_q <= 1'b0;
            ip_pend_q   <= 1'b0;
            ip_shadow_q <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
            ptt_sent_q  <= ptt_sent_d;
            boot_pend_q <= boot_pend_d;
            ip_pend_q   <= ip_pend_d;
            ip_shadow_q <= ip_shadow_d;
        end
    end

    assign tx_valid = vld_q;
    assign tx_data  = vld_q ? msg_q[71:64] : 8'h00;
    assign tx_last  = vld_q && last_byte;
    assign busy     = (state_q == ST_VER) || (state_q == ST_LOGO) || (state_q == ST_SEND);

endmodule

// File: tb/tb_pic_msg_builder.sv
// Directed bench for pic_msg_builder: a byte scoreboard fed at stimulus time and drained by a stream monitor.
module tb_pic_msg_builder;

    localparam int STARTUP_DELAY = 10;
    localparam int LOGO_DELAY    = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ptt = 1'b0;
    logic [31:0] ip_addr = '0;
    logic        ip_valid = 1'b0;
    logic        boot_req = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready = 1'b1;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    logic [8:0] sb[$];

    logic       prev_stall = 1'b0;
    logic       prev_last  = 1'b0;
    logic [8:0] prev_word  = '0;
    logic [8:0] exp_word;

    pic_msg_builder #(
        .FW_VERSION    (64'h6E6F207665720000),
        .STARTUP_DELAY (STARTUP_DELAY),
        .LOGO_DELAY    (LOGO_DELAY)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ptt      (ptt),
        .ip_addr  (ip_addr),
        .ip_valid (ip_valid),
        .boot_req (boot_req),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_msg(input logic [71:0] m, input int len);
        logic [71:0] t;
        t = m;
        for (int i = 0; i < len; i++) begin
            sb.push_back({t[71:64], (i == len - 1)});
            t = t << 8;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_valid || busy) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Stream monitor: scoreboard order, hold-under-stall and post-last gap.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_word", 32'({tx_data, tx_last}), 32'(prev_word));
            end
            if (prev_last) chk("gap_after_last", 32'(tx_valid), 32'd0);
            prev_stall = tx_valid && !tx_ready;
            prev_word  = {tx_data, tx_last};
            prev_last  = tx_valid && tx_ready && tx_last;
            if (tx_valid && tx_ready) begin
                xfers++;
                chk("unexpected_byte", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_word = sb.pop_front();
                    chk("byte", 32'({tx_data, tx_last}), 32'(exp_word));
                end
            end
        end
    end

    initial begin
        logic [71:0] ver_msg;
        logic        early;
        int          n;
        int          x0;
        ver_msg = {8'h01, 64'h6E6F207665720000};

        // Reset state and power-up sequence.
        repeat (3) step();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_last", 32'(tx_last), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        push_msg(ver_msg, 9);
        push_msg(72'h02 << 64, 1);
        reset = 1'b0;
        early = 1'b0;
        for (int i = 0; i < STARTUP_DELAY; i++) begin
            step();
            if (tx_valid || busy) early = 1'b1;
        end
        chk("startup_quiet", 32'(early), 32'd0);
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        chk("ver_start", 32'(tx_valid), 32'd1);
        chk("ver_busy", 32'(busy), 32'd1);
        n = 0;
        while (sb.size() > 1 && n < 100) begin
            step();
            n++;
        end
        n = 0;
        while (!tx_valid && n < 200) begin
            step();
            n++;
        end
        chk("logo_gap", 32'(n >= LOGO_DELAY), 32'd1);
        drain("startup", 50);

        // PTT edges in IDLE.
        ptt = 1'b1;
        push_msg(72'h05 << 64, 1);
        drain("ptt_on", 20);
        ptt = 1'b0;
        push_msg(72'h06 << 64, 1);
        drain("ptt_off", 20);

        // Three simultaneous requests: priority PTT > boot > IP.
        ptt      = 1'b1;
        boot_req = 1'b1;
        ip_valid = 1'b1;
        ip_addr  = 32'hC0A80164;
        push_msg(72'h05 << 64, 1);
        push_msg(72'h04 << 64, 1);
        push_msg(72'h03_01C0_02A8_0301_0464, 9);
        step();
        boot_req = 1'b0;
        ip_valid = 1'b0;
        drain("priority", 60);

        // Stall mid IP message.
        x0 = xfers;
        ip_addr  = 32'h11223344;
        ip_valid = 1'b1;
        push_msg(72'h03_0111_0222_0333_0444, 9);
        step();
        ip_valid = 1'b0;
        n = 0;
        while (sb.size() > 5 && n < 30) begin
            step();
            n++;
        end
        tx_ready = 1'b0;
        repeat (5) step();
        chk("stall_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        drain("stall", 40);
        chk("stall_xfers", 32'(xfers - x0), 32'd9);

        // Reset during byte 4 of the version message.
        reset = 1'b1;
        ptt   = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        push_msg(ver_msg, 9);
        n = 0;
        while (sb.size() > 6 && n < 60) begin
            step();
            n++;
        end
        chk("byte4_presented", 32'(tx_data), 32'h20);
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) step();
        reset = 1'b0;

        // Restarted sequence; IP updates and a PTT blip during WAIT1.
        push_msg(ver_msg, 9);
        push_msg(72'h02 << 64, 1);
        push_msg(72'h03_010A_0200_0300_0402, 9);
        n = 0;
        while (sb.size() > 10 && n < 100) begin
            step();
            n++;
        end
        chk("restart_ver", 32'(sb.size()), 32'd10);
        step();
        ip_addr  = 32'h0A000001;
        ip_valid = 1'b1;
        step();
        ip_valid = 1'b0;
        step();
        ip_addr  = 32'h0A000002;
        ip_valid = 1'b1;
        step();
        ip_valid = 1'b0;
        ptt      = 1'b1;
        repeat (2) step();
        ptt = 1'b0;
        drain("wait1_ip", 200);
        repeat (30) step();
        chk("quiet_end", 32'(tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
